// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4-function ALU (NOT, AND, OR, ADD).
// Each operation occupies the unit for IDLE->EXEC->DONE; results are registered with Z/CF.
module alu_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             cf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             last;
  logic             win;
  logic             win_next;
  logic             start;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   exec_res;

  // Returns {carry, result}; carry is only ever set by ADD.
  function automatic logic [WIDTH:0] alu_eval(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   alu_eval = {1'b0, ~a};
      2'b01:   alu_eval = {1'b0, a & b};
      2'b10:   alu_eval = {1'b0, a | b};
      default: alu_eval = {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  // On a tie the requester that did not win last time goes next.
  assign win_next = (req0 && req1) ? ~last : req1;
  assign start    = (state == IDLE) && (req0 || req1);
  assign exec_res = alu_eval(op_q, a_q, b_q);

  // Operand capture: no reset needed, only read in EXEC after a fresh latch.
  always_ff @(posedge clk) begin
    if (start) begin
      op_q <= win_next ? op1 : op0;
      a_q  <= win_next ? a1  : a0;
      b_q  <= win_next ? b1  : b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 1'b1;
      win    <= 1'b0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      result <= '0;
      z      <= 1'b0;
      cf     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            win   <= win_next;
            gnt0  <= ~win_next;
            gnt1  <= win_next;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          result <= exec_res[WIDTH-1:0];
          cf     <= exec_res[WIDTH];
          z      <= (exec_res[WIDTH-1:0] == '0);
          ack0   <= ~win;
          ack1   <= win;
          state  <= DONE;
        end
        DONE: begin
          last  <= win;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
